// File: rtl/axil_regfile_pkg.sv
// Shared constants and helpers for the AXI-lite register bank.
// Optional feature macro: AXIL_REGFILE_DECERR_EN (out-of-range accesses return DECERR).
package axil_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Register index width; REG_COUNT is a power of two, at least 2.
    function automatic int idx_width(input int reg_count);
        return $clog2(reg_count);
    endfunction

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[b*8 +: 8] = new_w[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/axil_regfile_wr.sv
// Write side of the register bank: AW/W holding registers, commit decision and B channel.
// With AXIL_REGFILE_DECERR_EN defined, out-of-range writes are dropped and answered with DECERR.
module axil_regfile_wr
    import axil_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int REG_COUNT  = 16,
    parameter int IDX_W      = idx_width(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [DATA_WIDTH-1:0] cur_word_i,
    output logic                  commit_o,
    output logic [IDX_W-1:0]      commit_idx_o,
    output logic [DATA_WIDTH-1:0] commit_data_o
);

    logic                  aw_held_q, w_held_q, bvalid_q;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [1:0]            bresp_q;

    logic                  aw_hs, w_hs, commit, in_range;
    logic [ADDR_WIDTH-1:0] addr_eff;
    logic [DATA_WIDTH-1:0] data_eff;
    logic [STRB_WIDTH-1:0] strb_eff;
    logic [1:0]            resp;
    logic                  unused_addr;

    assign s_axil_awready = !aw_held_q && !bvalid_q;
    assign s_axil_wready  = !w_held_q && !bvalid_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;

    assign aw_hs  = s_axil_awvalid && s_axil_awready;
    assign w_hs   = s_axil_wvalid && s_axil_wready;
    // A held beat or a live handshake counts as available, so same-cycle AW+W commits at once.
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign addr_eff = aw_held_q ? awaddr_q : s_axil_awaddr;
    assign data_eff = w_held_q ? wdata_q : s_axil_wdata;
    assign strb_eff = w_held_q ? wstrb_q : s_axil_wstrb;

`ifdef AXIL_REGFILE_DECERR_EN
    assign in_range = (addr_eff[ADDR_WIDTH-1:2] >> IDX_W) == '0;
    assign resp     = in_range ? RESP_OKAY : RESP_DECERR;
`else
    assign in_range = 1'b1;
    assign resp     = RESP_OKAY;
`endif

    assign commit_o      = commit && in_range;
    assign commit_idx_o  = addr_eff[IDX_W+1:2];
    assign commit_data_o = byte_merge(cur_word_i, data_eff, strb_eff);
    assign unused_addr   = ^addr_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= resp;
        end else begin
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s_axil_awaddr;
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axil_wdata;
                wstrb_q  <= s_axil_wstrb;
            end
            if (bvalid_q && s_axil_bready) bvalid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axil_regfile.sv
// AXI-lite slave register bank: REG_COUNT 32-bit registers, flat output bus, per-register write strobe.
// Define AXIL_REGFILE_DECERR_EN to answer out-of-range accesses with DECERR instead of aliasing.
module axil_regfile
    import axil_regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH/8,
    parameter int REG_COUNT  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
    input  logic [2:0]                      s_axil_awprot,
    input  logic                            s_axil_awvalid,
    output logic                            s_axil_awready,
    input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
    input  logic                            s_axil_wvalid,
    output logic                            s_axil_wready,
    output logic [1:0]                      s_axil_bresp,
    output logic                            s_axil_bvalid,
    input  logic                            s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
    input  logic [2:0]                      s_axil_arprot,
    input  logic                            s_axil_arvalid,
    output logic                            s_axil_arready,
    output logic [DATA_WIDTH-1:0]           s_axil_rdata,
    output logic [1:0]                      s_axil_rresp,
    output logic                            s_axil_rvalid,
    input  logic                            s_axil_rready,
    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q,
    output logic [REG_COUNT-1:0]            reg_wr_stb
);

    localparam int IW = idx_width(REG_COUNT);

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q;
    logic [REG_COUNT-1:0]                 stb_q;
    logic                                 wr_commit;
    logic [IW-1:0]                        wr_idx;
    logic [DATA_WIDTH-1:0]                wr_data;

    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  ar_hs, rd_in_range;
    logic [IW-1:0]         rd_idx;
    logic                  unused_in;

    axil_regfile_wr #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .STRB_WIDTH(STRB_WIDTH),
        .REG_COUNT (REG_COUNT),
        .IDX_W     (IW)
    ) u_wr (
        .clk           (clk),
        .rst           (rst),
        .s_axil_awaddr (s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid),
        .s_axil_awready(s_axil_awready),
        .s_axil_wdata  (s_axil_wdata),
        .s_axil_wstrb  (s_axil_wstrb),
        .s_axil_wvalid (s_axil_wvalid),
        .s_axil_wready (s_axil_wready),
        .s_axil_bresp  (s_axil_bresp),
        .s_axil_bvalid (s_axil_bvalid),
        .s_axil_bready (s_axil_bready),
        .cur_word_i    (regs_q[wr_idx]),
        .commit_o      (wr_commit),
        .commit_idx_o  (wr_idx),
        .commit_data_o (wr_data)
    );

    assign reg_q      = regs_q;
    assign reg_wr_stb = stb_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
            stb_q  <= '0;
        end else begin
            stb_q <= '0;
            if (wr_commit) begin
                regs_q[wr_idx] <= wr_data;
                stb_q[wr_idx]  <= 1'b1;
            end
        end
    end

    assign s_axil_arready = !rvalid_q || s_axil_rready;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;
    assign ar_hs          = s_axil_arvalid && s_axil_arready;
    assign rd_idx         = s_axil_araddr[IW+1:2];

`ifdef AXIL_REGFILE_DECERR_EN
    assign rd_in_range = (s_axil_araddr[ADDR_WIDTH-1:2] >> IW) == '0;
`else
    assign rd_in_range = 1'b1;
`endif

    assign unused_in = ^{s_axil_awprot, s_axil_arprot, s_axil_araddr};

    // Reads sample regs_q before this edge's write lands, so a colliding read sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_in_range ? regs_q[rd_idx] : '0;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_DECERR;
        end else if (s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule
